// File: rtl/motor_feedback_decoder.sv
// motor_feedback_decoder
//   Decodes the single-channel sensor feedback of an H-bridge motor into
//   speed (edges per window), edge-to-edge period, a stall flag and a signed
//   position count whose direction comes from the commanded DIR.
//
// Ports
//   clk          : single clock for all logic
//   reset        : asynchronous, active-high reset
//   fb           : raw sensor A feedback, asynchronous to clk
//   dir          : commanded direction (1 = forward), sampled on each rise
//   clear        : synchronous clear of all measurement state
//   edge_count   : rising edges counted in the last completed window
//   count_valid  : one-cycle pulse when edge_count updates
//   period       : clk cycles between the last two rising edges
//   period_valid : one-cycle pulse when period updates
//   stalled      : high while no rising edge has occurred for TIMEOUT cycles
//   position     : signed edge position accumulator, wraps modulo 2**32
module motor_feedback_decoder #(
    parameter int WINDOW_CYCLES = 1000000,
    parameter int CNT_W         = 16,
    parameter int PER_W         = 24,
    parameter int TIMEOUT       = 2**24-1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fb,
    input  logic                dir,
    input  logic                clear,
    output logic [CNT_W-1:0]    edge_count,
    output logic                count_valid,
    output logic [PER_W-1:0]    period,
    output logic                period_valid,
    output logic                stalled,
    output logic signed [31:0]  position
);

    localparam int              WIN_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [PER_W-1:0] TO       = PER_W'(TIMEOUT);
    localparam logic [PER_W-1:0] TO_M1    = PER_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Input synchronizer, history flop and post-reset blanking
    // ------------------------------------------------------------------
    logic       fb_s1, fb_s2, fb_hist;
    logic [1:0] blank_cnt;
    logic       rise;

    // The history flop needs three edges after reset to hold a real
    // synchronized sample; until then a high fb would look like a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_s1     <= 1'b0;
            fb_s2     <= 1'b0;
            fb_hist   <= 1'b0;
            blank_cnt <= 2'd0;
        end else begin
            fb_s1   <= fb;
            fb_s2   <= fb_s1;
            fb_hist <= fb_s2;
            if (blank_cnt != 2'd3)
                blank_cnt <= blank_cnt + 2'd1;
        end
    end

    assign rise = fb_s2 & ~fb_hist & (blank_cnt == 2'd3);

    // ------------------------------------------------------------------
    // Speed window
    // ------------------------------------------------------------------
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] acc;
    logic [CNT_W:0]   acc_sum;
    logic [CNT_W-1:0] acc_sat;
    logic             win_term;

    assign win_term = (win_cnt == WIN_LAST);
    assign acc_sum  = {1'b0, acc} + {{CNT_W{1'b0}}, rise};
    assign acc_sat  = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt     <= '0;
            acc         <= '0;
            edge_count  <= '0;
            count_valid <= 1'b0;
        end else if (clear) begin
            win_cnt     <= '0;
            acc         <= '0;
            edge_count  <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= win_term;
            if (win_term) begin
                // A rise on the terminal cycle belongs to the closing window.
                win_cnt    <= '0;
                edge_count <= acc_sat;
                acc        <= '0;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                acc     <= acc_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Period, stall detection and position
    // ------------------------------------------------------------------
    logic [PER_W-1:0] pcnt;
    logic             armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt         <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
            position     <= '0;
        end else if (clear) begin
            pcnt         <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
            position     <= '0;
        end else begin
            period_valid <= 1'b0;
            if (rise) begin
                // pcnt counts from 0 in the cycle after a rise, so the
                // rise-to-rise distance is pcnt + 1.
                if (armed) begin
                    period       <= pcnt + PER_W'(1);
                    period_valid <= 1'b1;
                end
                pcnt     <= '0;
                armed    <= 1'b1;
                stalled  <= 1'b0;
                position <= dir ? position + 32'sd1 : position - 32'sd1;
            end else if (pcnt != TO) begin
                pcnt <= pcnt + PER_W'(1);
                if (pcnt == TO_M1) begin
                    // Entering saturation: the next rise only re-arms.
                    stalled <= 1'b1;
                    armed   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_feedback_decoder.sv
// Randomized bench for motor_feedback_decoder. An event-level model (rise
// times, window sums, rise-to-rise distances) predicts every output each
// cycle; a few directed scenarios add hand-computed literal expectations.
module tb_motor_feedback_decoder;

    localparam int W    = 100;
    localparam int TOUT = 1000;
    localparam int MAXC = 8192;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               fb = 1'b0;
    logic               dir = 1'b0;
    logic               clear = 1'b0;
    logic [15:0]        edge_count;
    logic               count_valid;
    logic [23:0]        period;
    logic               period_valid;
    logic               stalled;
    logic signed [31:0] position;

    motor_feedback_decoder #(
        .WINDOW_CYCLES(W), .CNT_W(16), .PER_W(24), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .reset(reset), .fb(fb), .dir(dir), .clear(clear),
        .edge_count(edge_count), .count_valid(count_valid),
        .period(period), .period_valid(period_valid),
        .stalled(stalled), .position(position)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model. Cycle n counts from the first cycle after reset
    // release; fb_v[n] is the fb value sampled at the end of cycle n.
    // A rise is seen in cycle n when fb was 0 at the end of n-3 and 1 at
    // the end of n-2, never before cycle 3.
    // ------------------------------------------------------------------
    bit          fb_v [0:MAXC-1];
    bit          rz   [0:MAXC-1];
    int          n, ep, ref_a, last_rise;
    logic [15:0] m_cnt;
    logic [23:0] m_per;
    logic [31:0] m_pos;
    bit          m_cv, m_pv;

    always @(negedge clk) begin : compare
        bit r;
        int cnt;
        if (reset) begin
            chk("rst_edge_count", 32'(edge_count), 0);
            chk("rst_count_valid", 32'(count_valid), 0);
            chk("rst_period", 32'(period), 0);
            chk("rst_period_valid", 32'(period_valid), 0);
            chk("rst_stalled", 32'(stalled), 0);
            chk("rst_position", position, 0);
            n = 0; ep = 0; ref_a = 0; last_rise = -1;
            m_cnt = 0; m_per = 0; m_pos = 0; m_cv = 0; m_pv = 0;
        end else if (n >= MAXC) begin
            chk("model_range", 32'(n), 32'(MAXC - 1));
        end else begin
            chk("edge_count", 32'(edge_count), 32'(m_cnt));
            chk("count_valid", 32'(count_valid), 32'(m_cv));
            chk("period", 32'(period), 32'(m_per));
            chk("period_valid", 32'(period_valid), 32'(m_pv));
            chk("stalled", 32'(stalled), 32'(n >= ref_a + TOUT));
            chk("position", position, m_pos);

            fb_v[n] = fb;
            r = 1'b0;
            if (n >= 3) r = fb_v[n-2] && !fb_v[n-3];
            m_cv = 0;
            m_pv = 0;
            if (clear) begin
                rz[n] = 0;
                ep = n + 1; ref_a = n + 1; last_rise = -1;
                m_cnt = 0; m_per = 0; m_pos = 0;
            end else begin
                rz[n] = r;
                if (r) begin
                    if (last_rise >= 0 && n - last_rise <= TOUT) begin
                        m_per = 24'(n - last_rise);
                        m_pv  = 1;
                    end
                    last_rise = n;
                    ref_a = n + 1;
                    m_pos = dir ? m_pos + 1 : m_pos - 1;
                end
                if ((n - ep) % W == W - 1) begin
                    cnt = 0;
                    for (int i = n - W + 1; i <= n; i++) cnt += int'(rz[i]);
                    m_cnt = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
                    m_cv = 1;
                end
            end
            n++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int sn;

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sn = 0;
    endtask

    task automatic drive(input logic f);
        fb = f;
        @(posedge clk);
        #1;
        sn++;
    endtask

    task automatic run(input logic f, input int cyc);
        for (int i = 0; i < cyc; i++) drive(f);
    endtask

    // Square wave, period 20: low for 10, high for 10; rises land at 12+20k.
    task automatic wave(input int cyc);
        for (int i = 0; i < cyc; i++) drive((sn % 20) >= 10);
    endtask

    initial begin : stim
        logic f;
        int   hold;
        #1;
        // Square wave, forward, three-plus windows
        fb = 0; dir = 1;
        do_reset();
        wave(320);
        chk("lit_fwd_pos", position, 32'd16);
        chk("lit_fwd_count", 32'(edge_count), 32'd5);
        chk("lit_fwd_period", 32'(period), 32'd20);

        // Same wave, reverse
        fb = 0; dir = 0;
        do_reset();
        wave(300);
        chk("lit_rev_pos", position, 32'hFFFF_FFF1);
        chk("lit_rev_count", 32'(edge_count), 32'd5);

        // Stall after one edge (rise at cycle 7)
        fb = 0; dir = 1;
        do_reset();
        run(0, 5); run(1, 10); run(0, 992);
        chk("lit_stall_before", 32'(stalled), 32'd0);
        run(0, 1);
        chk("lit_stall_at", 32'(stalled), 32'd1);
        run(0, 207); run(1, 3);
        chk("lit_stall_cleared", 32'(stalled), 32'd0);
        chk("lit_stall_no_pv", 32'(period_valid), 32'd0);
        run(1, 7); run(0, 10); run(1, 3);
        chk("lit_rearm_pv", 32'(period_valid), 32'd1);
        chk("lit_rearm_period", 32'(period), 32'd20);
        run(1, 7); run(0, 10);

        // Rise detected on the window terminal cycle (cycle 99)
        fb = 0;
        do_reset();
        run(0, 97); run(1, 3);
        chk("lit_term_cv", 32'(count_valid), 32'd1);
        chk("lit_term_count", 32'(edge_count), 32'd1);
        run(1, 7); run(0, 120);

        // Clear in the same cycle as the third rise (cycle 52)
        fb = 0;
        do_reset();
        wave(52);
        chk("lit_preclear_pos", position, 32'd2);
        chk("lit_preclear_period", 32'(period), 32'd20);
        clear = 1;
        wave(1);
        clear = 0;
        chk("lit_clear_pos", position, 32'd0);
        chk("lit_clear_period", 32'(period), 32'd0);
        chk("lit_clear_pv", 32'(period_valid), 32'd0);
        wave(60);

        // fb high through reset release
        fb = 1;
        do_reset();
        run(1, 20);
        chk("lit_highrst_pos", position, 32'd0);
        run(0, 10); run(1, 18);
        chk("lit_highrst_rise", position, 32'd1);
        chk("lit_highrst_no_pv", 32'(period_valid), 32'd0);

        // Randomized epochs; each new reset lands mid-window/mid-period
        for (int e = 0; e < 4; e++) begin
            fb = 1'($urandom_range(0, 1));
            do_reset();
            f = fb;
            while (sn < 1500) begin
                f = ~f;
                hold = ($urandom_range(0, 39) == 0) ? 1100 : int'($urandom_range(1, 30));
                for (int i = 0; i < hold; i++) begin
                    if ($urandom_range(0, 7) == 0) dir = ~dir;
                    clear = ($urandom_range(0, 199) == 0);
                    drive(f);
                end
                clear = 0;
            end
        end

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/motor_feedback_decoder.md
MOTOR_FEEDBACK_DECODER -- requirements
Module: motor_feedback_decoder

Interface
REQ-001 Parameter WINDOW_CYCLES, default 1000000; speed sample window length in clk cycles (10 ms at 100 MHz), legal range 2 or more.
REQ-002 Parameter CNT_W, default 16; width of edge_count.
REQ-003 Parameter PER_W, default 24; width of period.
REQ-004 Parameter TIMEOUT, default 2**24-1; cycles without a rising edge before stall is declared, legal range 2 to 2**PER_W-1.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 fb  input  1  raw H-bridge sensor A feedback, asynchronous to clk.
REQ-008 dir  input  1  commanded motor direction, same signal that drives the bridge DIR pin; 1 = forward.
REQ-009 clear  input  1  synchronous clear of all measurement state.
REQ-010 edge_count  output  CNT_W  rising edges counted in the last completed window.
REQ-011 count_valid  output  1  one-cycle pulse when edge_count updates.
REQ-012 period  output  PER_W  clk cycles between the last two rising edges.
REQ-013 period_valid  output  1  one-cycle pulse when period updates.
REQ-014 stalled  output  1  high while no rising edge has occurred for TIMEOUT cycles.
REQ-015 position  output  32  signed two's-complement edge position accumulator.

Function
REQ-016 fb SHALL pass through a 2-flop synchronizer followed by a history flop; a rise is detected when the synchronized value is 1 and the history value is 0.
REQ-017 A rise SHALL be detected in the 2nd cycle after the first clk edge that samples fb=1, and one fb low-to-high transition SHALL yield exactly one rise.
REQ-018 The window counter SHALL run 0..WINDOW_CYCLES-1 and wrap; on the terminal cycle, edge_count SHALL load the window accumulator plus the rise in that cycle, the accumulator SHALL reset to 0, and count_valid SHALL pulse.
REQ-019 The window accumulator SHALL saturate at 2**CNT_W-1.
REQ-020 The period counter SHALL reset to 0 on each rise, increment otherwise, and saturate at TIMEOUT.
REQ-021 On a rise with the armed flag set, period SHALL load the counter value +1 and period_valid SHALL pulse; every rise SHALL set armed.
REQ-022 The first rise after reset, clear or stall SHALL only arm: no period update and no period_valid pulse.
REQ-023 When the period counter reaches TIMEOUT, stalled SHALL go to 1 and armed SHALL clear; period SHALL hold its last value.
REQ-024 stalled SHALL return to 0 in the cycle after the next rise.
REQ-025 On each rise, position SHALL increment by 1 if dir=1 and decrement by 1 if dir=0, sampling dir in the rise cycle, and SHALL wrap modulo 2**32.
REQ-026 clear SHALL zero the accumulator, window counter, period counter, armed, stalled, position, edge_count and period on the next clk edge.
REQ-027 clear SHALL take priority over a rise or window terminal in the same cycle: the edge is discarded and no valid pulses occur.
REQ-028 count_valid and period_valid SHALL be registered outputs; both may pulse in the same cycle.

Reset
REQ-029 While reset is asserted, all outputs and all internal flops SHALL be 0.
REQ-030 After reset deasserts, the history flop SHALL load the synchronized value without rise detection for 3 cycles, so fb held high across reset produces no rise.
REQ-031 Reset asserted mid-window or mid-period SHALL discard the partial measurement; the next window SHALL start at counter 0 on the first cycle after deassertion.

Verification (bench parameters: WINDOW_CYCLES=100, TIMEOUT=1000, CNT_W=16, PER_W=24)
REQ-032 Square wave on fb with period 20 clk, dir=1, for 3 windows -> count_valid every 100 cycles; edge_count=5 in steady state; period=20 with period_valid each edge after the first; position increases by 1 per edge.
REQ-033 Same wave with dir=0 from reset -> position reaches -15 after 15 edges; edge_count is unaffected by dir.
REQ-034 fb held low for 1200 cycles after one edge -> stalled=1 starting 1000 cycles after that edge; the next edge clears stalled with no period_valid; the edge after that gives period_valid.
REQ-035 fb rise timed so detection lands on the window terminal cycle -> the edge is counted in the closing window and the next window starts at 0.
REQ-036 clear asserted in the same cycle as a detected rise -> all outputs 0 the next cycle; no valid pulses; the next edge only arms.
REQ-037 fb held high through reset release -> no rise, position=0; first real rise after fb falls and rises again gives position=1 and no period_valid.
